operand_stack: RTL and testbench
================================

OPERAND_STACK -- requirements
Module: operand_stack

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8, width of one stack entry.
REQ-002 SHALL provide parameter DEPTH, default 16, total entries including TOS and NOS; power of two, minimum 4.
REQ-003 SHALL derive localparam CNT_WIDTH = clog2(DEPTH)+1, width of the occupancy count.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 op_valid  input  1  operation request.
REQ-008 op_ready  output  1  block can accept an operation this cycle.
REQ-009 op_code  input  3  000 NOP, 001 PUSH, 010 POP, 011 DUP_TOP, 100 ROT_TWO, 101 ROT_THREE, 110 POP_TWO, 111 CLEAR.
REQ-010 push_data  input  DATA_WIDTH  value for PUSH.
REQ-011 tos / nos  output  DATA_WIDTH each  top and second entries, registered.
REQ-012 depth  output  CNT_WIDTH  number of valid entries.
REQ-013 empty / full  output  1 each  depth==0 / depth==DEPTH, decoded from the count register.
REQ-014 overflow / underflow  output  1 each  sticky error flags.
REQ-015 clr_flags  input  1  clears both sticky flags.

Function
REQ-016 Storage: TOS and NOS registers plus a body RAM of DEPTH-2 entries with synchronous read; entry 3 and below live in the RAM.
REQ-017 An operation is accepted on a rising edge where op_valid and op_ready are both 1; op_ready is 1 exactly when the FSM is in IDLE.
REQ-018 FSM states: IDLE, FILL1 (one RAM refill), FILL2A/FILL2B (two refills), ROT3 (rotate write-back); every non-IDLE state lasts one cycle.
REQ-019 PUSH (depth<DEPTH): if depth>=2, body[depth-2]<=NOS; NOS<=TOS; TOS<=push_data; depth+1; single cycle.
REQ-020 DUP_TOP (1<=depth<DEPTH): same as PUSH with TOS as the pushed value.
REQ-021 POP (depth>=1): TOS<=NOS; depth-1. If depth>=3, read body[depth-3] at accept and load NOS in FILL1. Otherwise NOS<=0. When depth==1, TOS<=0.
REQ-022 POP_TWO (depth>=2): depth-2. TOS<=body[depth-3] if depth>=3, else 0. NOS<=body[depth-4] if depth>=4, else 0. Required reads use FILL2A then FILL2B; with only one read, FILL1; with none, single cycle.
REQ-023 ROT_TWO (depth>=2): swap TOS and NOS; single cycle.
REQ-024 ROT_THREE (depth>=3): new TOS=old NOS, new NOS=old third, new third=old TOS. At accept: read body[depth-3], TOS<=NOS, hold old TOS. In ROT3: NOS<=read data, body[depth-3]<=held value.
REQ-025 CLEAR: depth<=0, TOS<=0, NOS<=0, single cycle, any depth.
REQ-026 NOP: no state change.
REQ-027 Illegal op, when the stack conditions are not met:
  - PUSH or DUP_TOP at full: overflow<=1.
  - POP, POP_TWO, ROT_TWO, ROT_THREE, or DUP_TOP with too few entries: underflow<=1.
  - Stack contents and depth unchanged; single cycle.
REQ-028 Flag set and clr_flags in the same cycle: set wins.
REQ-029 Visible latency: tos/nos/depth reflect an accepted op on the next edge for single-cycle ops, and on the edge ending the last non-IDLE state otherwise. depth updates on the accept edge.
REQ-030 op_valid in non-IDLE states is ignored (not accepted); op_code/push_data are sampled only at accept.
REQ-031 Reads of empty slots never reach tos/nos: vacated positions read 0.

Reset
REQ-032 reset SHALL force state=IDLE, depth=0, tos=0, nos=0, overflow=0, underflow=0, so empty=1, full=0, op_ready=1 on the following cycle.
REQ-033 reset asserted in any non-IDLE state SHALL abort the operation with no RAM write; it takes priority over all other inputs.
REQ-034 RAM contents need no reset.

Verification
REQ-035 DEPTH=16: PUSH 1,2,3 -> tos=3, nos=2, depth=3; then POP -> op_ready low 1 cycle, tos=2, nos=1, depth=2.
REQ-036 PUSH 16 values 0..15 -> full=1, depth=16. PUSH 0xAA -> overflow=1, tos=15, depth=16. clr_flags -> overflow=0.
REQ-037 Stack [top 3,2,1]: ROT_THREE -> tos=2, nos=1, third=3 (confirm by POP, POP: tos=3). ROT_TWO on [3,2] -> tos=2, nos=3.
REQ-038 Empty stack: POP -> underflow=1, depth=0, tos=0. Same cycle with clr_flags=1 -> underflow=1.
REQ-039 Stack [top 5,4,3,2]: POP_TWO -> 2 busy cycles, tos=3, nos=2, depth=2. Then CLEAR -> depth=0, empty=1.
REQ-040 Stack [top 3,2,1]: accept POP, assert reset in FILL1 -> next cycle depth=0, tos=nos=0, op_ready=1, flags 0.

Source files
------------

// File: rtl/operand_stack.sv
// ============================================================================
// operand_stack
//
// Hardware operand stack for a stack-machine datapath. The two top entries
// (TOS, NOS) live in registers so they are always visible. Entry 3 and deeper
// live in a body RAM with a synchronous read port. Operations that need a
// value from the RAM take extra cycles to refill TOS/NOS. While they do,
// op_ready is low.
//
// Parameters
//   DATA_WIDTH  width of one stack entry
//   DEPTH       total entries including TOS and NOS (power of two, >= 4)
//   CNT_WIDTH   width of the occupancy count (derived)
//
// Ports
//   clk        rising-edge clock for all state
//   reset      synchronous active-high reset
//   op_valid   operation request
//   op_ready   high when the block can accept an operation (FSM in IDLE)
//   op_code    000 NOP, 001 PUSH, 010 POP, 011 DUP_TOP,
//              100 ROT_TWO, 101 ROT_THREE, 110 POP_TWO, 111 CLEAR
//   push_data  value pushed by PUSH
//   tos, nos   top and second entries (registered)
//   depth      number of valid entries
//   empty      depth == 0
//   full       depth == DEPTH
//   overflow   sticky: PUSH or DUP_TOP attempted on a full stack
//   underflow  sticky: an op needed more entries than were present
//   clr_flags  clears both sticky flags (a same-cycle set wins)
// ============================================================================
module operand_stack #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    localparam int CNT_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [2:0]            op_code,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic [DATA_WIDTH-1:0] tos,
    output logic [DATA_WIDTH-1:0] nos,
    output logic [CNT_WIDTH-1:0]  depth,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_flags
);

    // ------------------------------------------------------------------------
    // Local types and constants
    // ------------------------------------------------------------------------
    localparam int BODY_DEPTH = DEPTH - 2;
    localparam int ADDR_WIDTH = (BODY_DEPTH > 1) ? $clog2(BODY_DEPTH) : 1;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_TWO   = CNT_WIDTH'(2);
    localparam logic [CNT_WIDTH-1:0] CNT_THREE = CNT_WIDTH'(3);
    localparam logic [CNT_WIDTH-1:0] CNT_FOUR  = CNT_WIDTH'(4);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL  = CNT_WIDTH'(DEPTH);

    typedef enum logic [2:0] {
        OP_NOP       = 3'b000,
        OP_PUSH      = 3'b001,
        OP_POP       = 3'b010,
        OP_DUP_TOP   = 3'b011,
        OP_ROT_TWO   = 3'b100,
        OP_ROT_THREE = 3'b101,
        OP_POP_TWO   = 3'b110,
        OP_CLEAR     = 3'b111
    } op_t;

    typedef enum logic [2:0] {
        IDLE,    // accepting operations
        FILL1,   // one RAM word arrives, loaded into TOS or NOS
        FILL2A,  // first of two RAM words arrives (-> TOS), second read issued
        FILL2B,  // second RAM word arrives (-> NOS)
        ROT3     // rotated third entry written back, old third loaded into NOS
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t                state;
    logic                  fill_to_tos;   // FILL1 destination: 1 = TOS, 0 = NOS
    logic [DATA_WIDTH-1:0] held_tos;      // old TOS carried into ROT3

    // Body RAM: entry 3 of the stack is body[depth-3], so body[0] is the
    // oldest entry once the stack holds three or more values.
    logic [DATA_WIDTH-1:0] body_mem [BODY_DEPTH];
    logic [DATA_WIDTH-1:0] rd_data;

    // RAM port controls, decoded from the current state and request
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_re;
    logic [ADDR_WIDTH-1:0] mem_raddr;

    // ------------------------------------------------------------------------
    // Decodes
    // ------------------------------------------------------------------------
    op_t                   op;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] addr_m2;   // body slot of entry 2 (where NOS spills)
    logic [ADDR_WIDTH-1:0] addr_m3;   // body slot of entry 3 (top of the body)

    assign op       = op_t'(op_code);
    assign op_ready = (state == IDLE);
    assign accept   = op_valid && op_ready;
    assign empty    = (depth == CNT_ZERO);
    assign full     = (depth == CNT_FULL);

    // Only meaningful when the guarding depth check holds; wrap otherwise.
    assign addr_m2  = ADDR_WIDTH'(depth - CNT_TWO);
    assign addr_m3  = ADDR_WIDTH'(depth - CNT_THREE);

    // ------------------------------------------------------------------------
    // RAM port decode.
    //
    // After POP_TWO is accepted, depth already holds old_depth-2, so the
    // second refill address old_depth-4 is simply depth-2 during FILL2A.
    // ROT_THREE leaves depth unchanged, so the write-back slot in ROT3 is
    // depth-3, the same slot that was read at accept.
    // Writes are suppressed while reset is high so an aborted operation never
    // touches the RAM.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        mem_re    = 1'b0;
        mem_raddr = '0;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    unique case (op)
                        OP_PUSH: begin
                            if (!full && depth >= CNT_TWO) begin
                                mem_we    = 1'b1;
                                mem_waddr = addr_m2;
                                mem_wdata = nos;
                            end
                        end
                        OP_DUP_TOP: begin
                            if (!empty && !full && depth >= CNT_TWO) begin
                                mem_we    = 1'b1;
                                mem_waddr = addr_m2;
                                mem_wdata = nos;
                            end
                        end
                        OP_POP, OP_POP_TWO, OP_ROT_THREE: begin
                            if (depth >= CNT_THREE) begin
                                mem_re    = 1'b1;
                                mem_raddr = addr_m3;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            FILL2A: begin
                mem_re    = 1'b1;
                mem_raddr = addr_m2;
            end
            ROT3: begin
                mem_we    = 1'b1;
                mem_waddr = addr_m3;
                mem_wdata = held_tos;
            end
            default: ;
        endcase

        if (reset) begin
            mem_we = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Body RAM with registered read data.
    // ------------------------------------------------------------------------
    // NOTE: the RAM array and its read register are deliberately left out of
    // reset; reset logic on a memory prevents mapping it onto RAM macros, and
    // stale contents are never visible because depth gates every read.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            body_mem[mem_waddr] <= mem_wdata;
        end
        if (mem_re) begin
            rd_data <= body_mem[mem_raddr];
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM and stack registers.
    // ------------------------------------------------------------------------
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            depth       <= CNT_ZERO;
            tos         <= '0;
            nos         <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            fill_to_tos <= 1'b0;
            held_tos    <= '0;
        end else begin
            // Clear first; a flag set later in this block overrides the clear.
            if (clr_flags) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (accept) begin
                        unique case (op)
                            OP_NOP: ;

                            OP_PUSH: begin
                                if (full) begin
                                    overflow <= 1'b1;
                                end else begin
                                    nos   <= tos;
                                    tos   <= push_data;
                                    depth <= depth + CNT_ONE;
                                end
                            end

                            OP_DUP_TOP: begin
                                if (empty) begin
                                    underflow <= 1'b1;
                                end else if (full) begin
                                    overflow <= 1'b1;
                                end else begin
                                    nos   <= tos;
                                    depth <= depth + CNT_ONE;
                                end
                            end

                            OP_POP: begin
                                if (empty) begin
                                    underflow <= 1'b1;
                                end else begin
                                    depth <= depth - CNT_ONE;
                                    if (depth == CNT_ONE) begin
                                        tos <= '0;
                                    end else begin
                                        tos <= nos;
                                    end
                                    if (depth >= CNT_THREE) begin
                                        fill_to_tos <= 1'b0;
                                        state       <= FILL1;
                                    end else begin
                                        nos <= '0;
                                    end
                                end
                            end

                            OP_ROT_TWO: begin
                                if (depth < CNT_TWO) begin
                                    underflow <= 1'b1;
                                end else begin
                                    tos <= nos;
                                    nos <= tos;
                                end
                            end

                            OP_ROT_THREE: begin
                                if (depth < CNT_THREE) begin
                                    underflow <= 1'b1;
                                end else begin
                                    tos      <= nos;
                                    held_tos <= tos;
                                    state    <= ROT3;
                                end
                            end

                            OP_POP_TWO: begin
                                if (depth < CNT_TWO) begin
                                    underflow <= 1'b1;
                                end else begin
                                    depth <= depth - CNT_TWO;
                                    if (depth >= CNT_FOUR) begin
                                        state <= FILL2A;
                                    end else if (depth == CNT_THREE) begin
                                        // Only one entry remains: it comes
                                        // from the RAM into TOS.
                                        nos         <= '0;
                                        fill_to_tos <= 1'b1;
                                        state       <= FILL1;
                                    end else begin
                                        tos <= '0;
                                        nos <= '0;
                                    end
                                end
                            end

                            OP_CLEAR: begin
                                depth <= CNT_ZERO;
                                tos   <= '0;
                                nos   <= '0;
                            end

                            default: ;
                        endcase
                    end
                end

                FILL1: begin
                    if (fill_to_tos) begin
                        tos <= rd_data;
                    end else begin
                        nos <= rd_data;
                    end
                    state <= IDLE;
                end

                FILL2A: begin
                    tos   <= rd_data;
                    state <= FILL2B;
                end

                FILL2B: begin
                    nos   <= rd_data;
                    state <= IDLE;
                end

                ROT3: begin
                    nos   <= rd_data;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_stack.sv
// ============================================================================
// tb_operand_stack
//
// Directed scoreboard bench for operand_stack (DATA_WIDTH=8, DEPTH=16).
// The driver issues one operation at a time and pushes the hand-computed
// expected result into a queue. The monitor pops and compares an expected
// entry when the DUT returns to op_ready after an accepted operation. It also
// counts the cycles op_ready stayed low.
// ============================================================================
module tb_operand_stack;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    localparam logic [2:0] NOP   = 3'b000;
    localparam logic [2:0] PUSH  = 3'b001;
    localparam logic [2:0] POP   = 3'b010;
    localparam logic [2:0] DUP   = 3'b011;
    localparam logic [2:0] ROT2  = 3'b100;
    localparam logic [2:0] ROT3  = 3'b101;
    localparam logic [2:0] POP2  = 3'b110;
    localparam logic [2:0] CLEAR = 3'b111;

    typedef struct {
        string       name;
        logic [63:0] state;   // {tos, nos, depth, empty, full, overflow, underflow}
        int          busy;    // cycles op_ready is expected low
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          op_valid;
    logic          op_ready;
    logic [2:0]    op_code;
    logic [DW-1:0] push_data;
    logic [DW-1:0] tos;
    logic [DW-1:0] nos;
    logic [CW-1:0] depth;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          underflow;
    logic          clr_flags;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   pending = 0;
    int   busy_cnt = 0;

    operand_stack #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_code   (op_code),
        .push_data (push_data),
        .tos       (tos),
        .nos       (nos),
        .depth     (depth),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow),
        .clr_flags (clr_flags)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pack_state(
        input logic [DW-1:0] t, input logic [DW-1:0] n, input logic [CW-1:0] d,
        input logic e, input logic f, input logic ov, input logic un);
        return 64'({t, n, d, e, f, ov, un});
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected visible state after an op, written by hand; empty/full follow
    // from the expected depth.
    task automatic issue(input string name, input logic [2:0] code, input logic [DW-1:0] data,
                         input logic clr, input logic [DW-1:0] e_tos, input logic [DW-1:0] e_nos,
                         input int e_depth, input logic e_ov, input logic e_un, input int e_busy,
                         input bit reset_mid = 0);
        exp_t e;
        int   guard;
        guard = 0;
        @(negedge clk);
        while (!op_ready && guard < 20) begin
            guard++;
            @(negedge clk);
        end
        if (!op_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: op_ready never returned before issue", name);
        end
        e.name  = name;
        e.state = pack_state(e_tos, e_nos, CW'(e_depth), e_depth == 0, e_depth == DEPTH, e_ov, e_un);
        e.busy  = e_busy;
        exp_q.push_back(e);
        op_valid  = 1'b1;
        op_code   = code;
        push_data = data;
        clr_flags = clr;
        @(posedge clk);
        #1;
        op_valid  = 1'b0;
        op_code   = NOP;
        push_data = '0;
        clr_flags = 1'b0;
        if (reset_mid) begin
            @(negedge clk);
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
        end
    endtask

    // Monitor: note accepts on the rising edge, compare on the falling edge
    // once the DUT is ready again.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (op_valid && op_ready && !reset) begin
                pending  = 1;
                busy_cnt = 0;
            end
            @(negedge clk);
            if (pending) begin
                if (!op_ready) begin
                    busy_cnt++;
                    if (busy_cnt > 10) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL busy_timeout: op_ready low %0d cycles", busy_cnt);
                        pending = 0;
                    end
                end else begin
                    pending = 0;
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL scoreboard: completion with no expected entry");
                    end else begin
                        e = exp_q.pop_front();
                        check(e.name, pack_state(tos, nos, depth, empty, full, overflow, underflow),
                              e.state);
                        check({e.name, "_busy"}, 64'(busy_cnt), 64'(e.busy));
                    end
                end
            end
        end
    end

    initial begin
        int guard;
        reset     = 1'b1;
        op_valid  = 1'b0;
        op_code   = NOP;
        push_data = '0;
        clr_flags = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_state", pack_state(tos, nos, depth, empty, full, overflow, underflow),
              pack_state(8'd0, 8'd0, '0, 1'b1, 1'b0, 1'b0, 1'b0));
        check("reset_ready", 64'(op_ready), 64'd1);

        // Basic push/pop, POP refill from RAM
        issue("push1", PUSH, 8'd1, 0, 8'd1, 8'd0, 1, 0, 0, 0);
        issue("push2", PUSH, 8'd2, 0, 8'd2, 8'd1, 2, 0, 0, 0);
        issue("push3", PUSH, 8'd3, 0, 8'd3, 8'd2, 3, 0, 0, 0);
        issue("pop_d3", POP, 8'd0, 0, 8'd2, 8'd1, 2, 0, 0, 1);

        // ROT_THREE on [3,2,1], confirm the third entry by popping
        issue("push3b", PUSH, 8'd3, 0, 8'd3, 8'd2, 3, 0, 0, 0);
        issue("rot3", ROT3, 8'd0, 0, 8'd2, 8'd1, 3, 0, 0, 1);
        issue("rot3_pop1", POP, 8'd0, 0, 8'd1, 8'd3, 2, 0, 0, 1);
        issue("rot3_pop2", POP, 8'd0, 0, 8'd3, 8'd0, 1, 0, 0, 0);

        // ROT_TWO on [3,2]
        issue("clear1", CLEAR, 8'd0, 0, 8'd0, 8'd0, 0, 0, 0, 0);
        issue("push2c", PUSH, 8'd2, 0, 8'd2, 8'd0, 1, 0, 0, 0);
        issue("push3c", PUSH, 8'd3, 0, 8'd3, 8'd2, 2, 0, 0, 0);
        issue("rot2", ROT2, 8'd0, 0, 8'd2, 8'd3, 2, 0, 0, 0);
        issue("pop_d2", POP, 8'd0, 0, 8'd3, 8'd0, 1, 0, 0, 0);
        issue("pop_d1", POP, 8'd0, 0, 8'd0, 8'd0, 0, 0, 0, 0);

        // Underflow on empty with clr_flags in the same cycle: set wins
        issue("pop_empty_clr", POP, 8'd0, 1, 8'd0, 8'd0, 0, 0, 1, 0);
        issue("nop_clr_un", NOP, 8'd0, 1, 8'd0, 8'd0, 0, 0, 0, 0);

        // Fill to full, then overflow
        for (int i = 0; i < DEPTH; i++) begin
            issue($sformatf("fill_%0d", i), PUSH, 8'(i), 0, 8'(i), (i == 0) ? 8'd0 : 8'(i - 1),
                  i + 1, 0, 0, 0);
        end
        issue("push_full", PUSH, 8'hAA, 0, 8'd15, 8'd14, 16, 1, 0, 0);
        issue("nop_clr_ov", NOP, 8'd0, 1, 8'd15, 8'd14, 16, 0, 0, 0);
        issue("dup_full", DUP, 8'd0, 0, 8'd15, 8'd14, 16, 1, 0, 0);
        issue("pop2_full", POP2, 8'd0, 0, 8'd13, 8'd12, 14, 1, 0, 2);
        issue("nop_clr_ov2", NOP, 8'd0, 1, 8'd13, 8'd12, 14, 0, 0, 0);

        // POP_TWO on [5,4,3,2], then CLEAR
        issue("clear2", CLEAR, 8'd0, 0, 8'd0, 8'd0, 0, 0, 0, 0);
        issue("p2_push2", PUSH, 8'd2, 0, 8'd2, 8'd0, 1, 0, 0, 0);
        issue("p2_push3", PUSH, 8'd3, 0, 8'd3, 8'd2, 2, 0, 0, 0);
        issue("p2_push4", PUSH, 8'd4, 0, 8'd4, 8'd3, 3, 0, 0, 0);
        issue("p2_push5", PUSH, 8'd5, 0, 8'd5, 8'd4, 4, 0, 0, 0);
        issue("pop2_d4", POP2, 8'd0, 0, 8'd3, 8'd2, 2, 0, 0, 2);
        issue("clear3", CLEAR, 8'd0, 0, 8'd0, 8'd0, 0, 0, 0, 0);

        // POP_TWO with one RAM read, DUP_TOP, underflow cases
        issue("q_push1", PUSH, 8'd1, 0, 8'd1, 8'd0, 1, 0, 0, 0);
        issue("q_push2", PUSH, 8'd2, 0, 8'd2, 8'd1, 2, 0, 0, 0);
        issue("q_push3", PUSH, 8'd3, 0, 8'd3, 8'd2, 3, 0, 0, 0);
        issue("pop2_d3", POP2, 8'd0, 0, 8'd1, 8'd0, 1, 0, 0, 1);
        issue("dup_d1", DUP, 8'd0, 0, 8'd1, 8'd1, 2, 0, 0, 0);
        issue("rot3_d2", ROT3, 8'd0, 0, 8'd1, 8'd1, 2, 0, 1, 0);
        issue("pop2_d2", POP2, 8'd0, 1, 8'd0, 8'd0, 0, 0, 0, 0);
        issue("rot2_d0", ROT2, 8'd0, 0, 8'd0, 8'd0, 0, 0, 1, 0);
        issue("dup_d0", DUP, 8'd0, 1, 8'd0, 8'd0, 0, 0, 1, 0);
        issue("nop_clr_un2", NOP, 8'd0, 1, 8'd0, 8'd0, 0, 0, 0, 0);

        // Reset during FILL1 aborts the POP
        issue("r_push1", PUSH, 8'd1, 0, 8'd1, 8'd0, 1, 0, 0, 0);
        issue("r_push2", PUSH, 8'd2, 0, 8'd2, 8'd1, 2, 0, 0, 0);
        issue("r_push3", PUSH, 8'd3, 0, 8'd3, 8'd2, 3, 0, 0, 0);
        issue("pop_reset", POP, 8'd0, 0, 8'd0, 8'd0, 0, 0, 0, 1, 1);
        issue("post_reset_push", PUSH, 8'd7, 0, 8'd7, 8'd0, 1, 0, 0, 0);

        guard = 0;
        while ((exp_q.size() != 0 || pending) && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        if (exp_q.size() != 0 || pending) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expected entries left", exp_q.size());
        end
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
